pll_spi_master: RTL and testbench

SPI bit engine between the PLL bring-up sequencer and the Si5341-class clock PLL pins. It consumes one command per handshake (read or write of one 8-bit register) and expands it into the PLL's instruction protocol: a Set-Address frame followed by a Write-Data or Read-Data frame. It returns if_done, and if_rdata for reads. It is SPI mode 0, 4-wire, and is clocked on the sequencer's clk.

---
 rtl/pll_spi_master.sv | 137 +++++++++++++
 tb/tb_pll_spi_master.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pll_spi_master.sv
// pll_spi_master: SPI mode-0 engine turning register commands into PLL set-address + data frames.
// Define PLL_SPI_ADDR_CACHE_EN to skip the set-address frame when the address is unchanged.
module pll_spi_master #(
   parameter int CLK_DIV = 4,
   parameter int CS_GAP  = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       if_reset,
   input  logic       if_read,
   input  logic       if_write,
   input  logic [7:0] if_addr,
   input  logic [7:0] if_wdata,
   output logic [7:0] if_rdata,
   output logic       if_done,
   output logic       busy,
   output logic       spi_csn,
   output logic       spi_sclk,
   output logic       spi_mosi,
   input  logic       spi_miso
);
   typedef enum logic [2:0] {IDLE, START, FRAME1, GAP, FRAME2, DONE} state_t;
   localparam int DW = $clog2(CLK_DIV);
   localparam int GW = $clog2(CS_GAP + 1);
   state_t state;
   logic is_rd, is_wr, hit, last_div, frame_end, abort;
   logic [7:0] addr, wdata, rx;
   logic [15:0] sh, frame2;
   logic [DW-1:0] div;
   logic [5:0] h;
   logic [GW-1:0] gap;
   assign last_div  = div == DW'(CLK_DIV - 1);
   assign frame_end = last_div && h == 6'd33;
   assign abort     = if_reset && (state inside {START, FRAME1, GAP, FRAME2});
   assign frame2    = is_wr ? {8'h40, wdata} : 16'h8000;
`ifdef PLL_SPI_ADDR_CACHE_EN
   logic [7:0] cache_addr;
   logic cache_vld;
   assign hit = cache_vld && cache_addr == addr;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         cache_vld  <= 1'b0;
         cache_addr <= 8'h00;
      end else if (abort) cache_vld <= 1'b0;
      else if (frame_end && state == FRAME1) begin
         cache_vld  <= 1'b1;
         cache_addr <= addr;
      end else if (frame_end && state == FRAME2 && is_wr && addr == 8'h01) cache_vld <= 1'b0;
`else
   assign hit = 1'b0;
`endif
   // h counts half-periods in a frame: 0 setup, 1..32 bit halves (even = sclk high), 33 hold
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state    <= IDLE;
         spi_csn  <= 1'b1;
         spi_sclk <= 1'b0;
         spi_mosi <= 1'b0;
         if_done  <= 1'b0;
         busy     <= 1'b0;
         if_rdata <= 8'h00;
         is_rd    <= 1'b0;
         is_wr    <= 1'b0;
         addr     <= 8'h00;
         wdata    <= 8'h00;
         rx       <= 8'h00;
         sh       <= 16'h0000;
         div      <= '0;
         h        <= 6'd0;
         gap      <= '0;
      end else if (abort) begin
         state    <= IDLE;
         spi_csn  <= 1'b1;
         spi_sclk <= 1'b0;
         spi_mosi <= 1'b0;
         busy     <= 1'b0;
         if_done  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (!if_reset) begin
               state <= START;
               busy  <= 1'b1;
               is_rd <= if_read;
               is_wr <= if_write;
               addr  <= if_addr;
               wdata <= if_wdata;
            end
            START: if (!is_rd && !is_wr) begin
               state <= DONE;
               busy  <= 1'b0;
            end else begin
               state    <= hit ? FRAME2 : FRAME1;
               sh       <= hit ? frame2 : {8'h00, addr};
               spi_mosi <= hit ? frame2[15] : 1'b0;
               spi_csn  <= 1'b0;
               div      <= '0;
               h        <= 6'd0;
            end
            FRAME1, FRAME2: begin
               div <= last_div ? '0 : div + 1'b1;
               if (frame_end) begin
                  spi_csn  <= 1'b1;
                  spi_sclk <= 1'b0;
                  spi_mosi <= 1'b0;
                  gap      <= '0;
                  state    <= (state == FRAME1) ? GAP : DONE;
                  if (state == FRAME2) begin
                     if_done <= 1'b1;
                     busy    <= 1'b0;
                     if (is_rd && !is_wr) if_rdata <= rx;
                  end
               end else if (last_div) begin
                  h        <= h + 6'd1;
                  spi_sclk <= h[0];
                  if (h[0]) rx <= {rx[6:0], spi_miso};
                  else if (h != 6'd0 && h != 6'd32) begin
                     sh       <= {sh[14:0], 1'b0};
                     spi_mosi <= sh[14];
                  end
               end
            end
            GAP: if (gap == GW'(CS_GAP - 1)) begin
               state    <= FRAME2;
               sh       <= frame2;
               spi_mosi <= frame2[15];
               spi_csn  <= 1'b0;
               div      <= '0;
               h        <= 6'd0;
            end else gap <= gap + 1'b1;
            DONE: if (if_reset) begin
               if_done <= 1'b0;
               state   <= IDLE;
            end else if_done <= 1'b1;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_pll_spi_master.sv
// tb_pll_spi_master: command table plus hand sequences, SPI frames checked against an expected-frame queue.
module tb_pll_spi_master;
   localparam int CLK_DIV = 4;
   localparam int CS_GAP  = 8;
   localparam int FLAT    = 1 + 68 * CLK_DIV + CS_GAP;
   typedef struct {
      logic       rd;
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] miso;
      logic [7:0] rdata;
      int         lat;
   } vec_t;
   typedef struct {
      logic [15:0] data;
      int          gap;
   } frm_t;
   logic clk = 1'b0, reset_n = 1'b0, if_reset = 1'b1, if_read = 1'b0, if_write = 1'b0, spi_miso = 1'b0;
   logic [7:0] if_addr = 8'h00, if_wdata = 8'h00, if_rdata, miso_val = 8'h00;
   logic if_done, busy, spi_csn, spi_sclk, spi_mosi;
   int tests = 0, errs = 0;
   frm_t exp_q[$];
   frm_t e;
   logic [15:0] bits = 16'h0, sr = 16'h0;
   logic p_csn = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0;
   int nb = 0, lo = 0, hi = 0, gap_seen = 0, bad = 0, idle_bad = 0;

   pll_spi_master #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
      .clk(clk), .reset_n(reset_n), .if_reset(if_reset), .if_read(if_read), .if_write(if_write),
      .if_addr(if_addr), .if_wdata(if_wdata), .if_rdata(if_rdata), .if_done(if_done), .busy(busy),
      .spi_csn(spi_csn), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // PLL model: shifts miso out MSB first, next bit after each sclk fall
   always @(negedge spi_csn) begin
      sr = {8'h00, miso_val};
      spi_miso = sr[15];
   end
   always @(negedge spi_sclk) if (!spi_csn) begin
      sr = {sr[14:0], 1'b0};
      spi_miso = sr[15];
   end

   always @(negedge clk) begin
      if (!spi_csn) begin
         if (p_csn) begin
            bits = 16'h0; nb = 0; lo = 0; bad = 0; gap_seen = hi;
         end
         lo++;
         if (spi_sclk && !p_sclk) begin
            bits = {bits[14:0], spi_mosi};
            nb++;
         end
         if (spi_sclk && p_sclk && spi_mosi != p_mosi) bad = 1;
      end else begin
         if (!p_csn) begin
            if (exp_q.size() == 0) chk("unexpected_frame", 1, 0);
            else begin
               e = exp_q.pop_front();
               if (e.gap != -2) begin
                  chk("frame_data", bits, e.data);
                  chk("frame_bits", nb, 16);
                  chk("frame_len", lo, 34 * CLK_DIV);
                  chk("mosi_stable", bad, 0);
                  if (e.gap >= 0) chk("cs_gap", gap_seen, e.gap);
               end
            end
         end
         hi = p_csn ? hi + 1 : 1;
         if (reset_n && (spi_mosi || spi_sclk)) idle_bad = 1;
      end
      p_csn = spi_csn; p_sclk = spi_sclk; p_mosi = spi_mosi;
   end

   task automatic run_cmd(input vec_t v, input bit hit);
      int lat;
      @(negedge clk);
      if_read = v.rd; if_write = v.wr; if_addr = v.addr; if_wdata = v.wdata; miso_val = v.miso;
      if (v.rd || v.wr) begin
         if (!hit) exp_q.push_back('{{8'h00, v.addr}, -1});
         exp_q.push_back('{v.wr ? {8'h40, v.wdata} : 16'h8000, hit ? -1 : CS_GAP});
      end
      if_reset = 1'b0;
      @(posedge clk); #1;
      chk("busy_start", busy, 1);
      if_read = ~v.rd; if_write = ~v.wr; if_addr = ~v.addr; if_wdata = ~v.wdata;
      lat = 0;
      while (!if_done && lat < 2000) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("done_lat", lat, v.lat);
      chk("rdata", if_rdata, v.rdata);
      chk("busy_end", busy, 0);
      chk("csn_end", spi_csn, 1);
      repeat (20) @(negedge clk);
      chk("done_hold", if_done, 1);
      chk("no_restart", spi_csn, 1);
      if_reset = 1'b1;
      @(posedge clk); #1;
      chk("done_clear", if_done, 0);
   endtask

   initial begin
      vec_t tbl[6];
      tbl[0] = '{1'b0, 1'b1, 8'h01, 8'h09, 8'h00, 8'h00, FLAT};
      tbl[1] = '{1'b1, 1'b0, 8'h02, 8'h00, 8'h41, 8'h41, FLAT};
      tbl[2] = '{1'b0, 1'b0, 8'h33, 8'h55, 8'h00, 8'h41, 2};
      tbl[3] = '{1'b1, 1'b1, 8'h10, 8'h5A, 8'hFF, 8'h41, FLAT};
      tbl[4] = '{1'b1, 1'b0, 8'hFE, 8'h00, 8'hA5, 8'hA5, FLAT};
      tbl[5] = '{1'b0, 1'b1, 8'h80, 8'hC3, 8'h00, 8'hA5, FLAT};
      repeat (3) @(negedge clk);
      chk("rst_csn", spi_csn, 1);
      chk("rst_sclk", spi_sclk, 0);
      chk("rst_mosi", spi_mosi, 0);
      chk("rst_done", if_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rdata", if_rdata, 0);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("idle_csn", spi_csn, 1);
      chk("idle_busy", busy, 0);
      for (int i = 0; i < 6; i++) run_cmd(tbl[i], 1'b0);
      // abort in the middle of the set-address frame
      @(negedge clk);
      if_read = 1'b0; if_write = 1'b1; if_addr = 8'h33; if_wdata = 8'h44; if_reset = 1'b0;
      exp_q.push_back('{16'h0, -2});
      @(posedge clk);
      repeat (50) @(posedge clk);
      #1 chk("abort_pre_csn", spi_csn, 0);
      @(negedge clk) if_reset = 1'b1;
      @(posedge clk); #1;
      chk("abort_csn", spi_csn, 1);
      chk("abort_sclk", spi_sclk, 0);
      chk("abort_mosi", spi_mosi, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", if_done, 0);
      repeat (300) @(negedge clk);
      chk("abort_no_done", if_done, 0);
      chk("abort_rdata", if_rdata, 8'hA5);
      run_cmd('{1'b0, 1'b1, 8'h2B, 8'h0A, 8'h00, 8'hA5, FLAT}, 1'b0);
      // asynchronous reset during the data frame of a read
      @(negedge clk);
      if_read = 1'b1; if_write = 1'b0; if_addr = 8'h02; miso_val = 8'h77; if_reset = 1'b0;
      exp_q.push_back('{16'h0002, -1});
      exp_q.push_back('{16'h0, -2});
      @(posedge clk);
      repeat (200) @(posedge clk);
      #1 chk("arst_pre_csn", spi_csn, 0);
      #2 reset_n = 1'b0; if_reset = 1'b1;
      #1;
      chk("arst_csn", spi_csn, 1);
      chk("arst_sclk", spi_sclk, 0);
      chk("arst_mosi", spi_mosi, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", if_done, 0);
      chk("arst_rdata", if_rdata, 0);
      @(negedge clk) reset_n = 1'b1;
      run_cmd('{1'b1, 1'b0, 8'h0C, 8'h00, 8'h3C, 8'h3C, FLAT}, 1'b0);
`ifdef PLL_SPI_ADDR_CACHE_EN
      run_cmd('{1'b1, 1'b0, 8'h0C, 8'h00, 8'hC3, 8'hC3, 1 + 34 * CLK_DIV}, 1'b1);
      run_cmd('{1'b0, 1'b1, 8'h01, 8'h09, 8'h00, 8'hC3, FLAT}, 1'b0);
      run_cmd('{1'b1, 1'b0, 8'h0C, 8'h00, 8'h5A, 8'h5A, FLAT}, 1'b0);
`endif
      repeat (5) @(negedge clk);
      chk("idle_mosi_sclk", idle_bad, 0);
      chk("frames_pending", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, errs);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
      $fatal(1);
   end
endmodule
